// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier (datapath and control).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default operand width, iteration-counter width helper, strobe bundle.
package mult_pkg;

  localparam int MULT_WIDTH_DEFAULT = 32;

  // Counter must be able to hold the terminal value WIDTH itself.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Control-to-datapath strobes, one bit each.
  typedef struct packed {
    logic lm;
    logic lp;
    logic sm;
    logic count;
  } mult_strobe_t;

endpackage

// File: rtl/mult_dp_counter.sv
// Saturating iteration counter for the multiplier datapath.
// Latency: done is a pure register decode, visible the cycle after the terminal increment.
// Backpressure: none; en is ignored once the terminal count is reached.
// Ports: clk, reset (async, active-high), clr (restart from 0, wins over en),
//        en (advance by one), done (counter == WIDTH).
module mult_dp_counter
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  TERM = CW'(WIDTH);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !done) begin
      cnt <= cnt + ONE;
    end
  end

  assign done = (cnt == TERM);

endmodule

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: holds M, Q, P and the iteration counter, driven by mult_control strobes.
// Latency: WIDTH+1 edges from lm to done when lp+sm+count are driven back to back.
// Backpressure: none; idle strobe cycles simply stall, strobes are ignored while done is high.
// Ports: clk, reset (async, active-high), lm/lp/sm/count strobes, mcand/mplier operands
//        (sampled on lm only), done (counter == WIDTH), product (2*WIDTH, valid while done).
// Option: define MULT_DATAPATH_SIGNED_EN for two's-complement operands (sign-magnitude internally).
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT  // legal 2..64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lm,
  input  logic               lp,
  input  logic               sm,
  input  logic               count,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  mult_strobe_t       stb;
  logic [2*WIDTH-1:0] m;
  logic [WIDTH-1:0]   q;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   mcand_mag;
  logic [WIDTH-1:0]   mplier_mag;

  assign stb = {lm, lp, sm, count};

`ifdef MULT_DATAPATH_SIGNED_EN
  logic sgn;

  // The most negative value negates to itself, which is exactly its
  // magnitude when read as unsigned, so no special case is needed.
  assign mcand_mag  = mcand[WIDTH-1]  ? -mcand  : mcand;
  assign mplier_mag = mplier[WIDTH-1] ? -mplier : mplier;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sgn <= 1'b0;
    end else if (stb.lm) begin
      sgn <= mcand[WIDTH-1] ^ mplier[WIDTH-1];
    end
  end

  assign product = sgn ? -p : p;
`else
  assign mcand_mag  = mcand;
  assign mplier_mag = mplier;
  assign product    = p;
`endif

  // lm restarts everything; once done, the operands and result freeze
  // until the next lm. The add sees the pre-shift M and Q[0] when lp
  // and sm share an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m <= '0;
      q <= '0;
      p <= '0;
    end else if (stb.lm) begin
      m <= {{WIDTH{1'b0}}, mcand_mag};
      q <= mplier_mag;
      p <= '0;
    end else if (!done) begin
      if (stb.lp && q[0]) begin
        p <= p + m;
      end
      if (stb.sm) begin
        m <= m << 1;
        q <= q >> 1;
      end
    end
  end

  mult_dp_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (stb.lm),
    .en    (stb.count),
    .done  (done)
  );

endmodule
